// File: rtl/game_state_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_state_controller : tunnel-game master FSM, frame score, level, LFSR feed
// Revision: 1.0
// ----------------------------------------------------------------------------
module game_state_controller #(
  parameter logic [15:0] LEVEL_UP_SCORE = 16'd600,
  parameter int          SCORE_W        = 16,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_start,
  input  logic [9:0]         Pixel_row,
  input  logic [9:0]         Pixel_column,
  input  logic               collison_detect,
  output logic [7:0]         game_info_reg,
  output logic [7:0]         randomized_value,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [SCORE_W-1:0] LEVEL_THRESH = SCORE_W'(LEVEL_UP_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               pix_zero;
  logic               pix_zero_d;
  logic               start_d;
  logic               frame_tick;
  logic               start_pulse;
  logic [SCORE_W-1:0] score_next;
  logic [1:0]         dir;
  logic               level;
  logic [7:0]         info_next;
  logic               game_over_next;
  logic               lfsr_fb;
  logic [7:0]         lfsr_next;

  assign pix_zero    = (Pixel_row == 10'd0) && (Pixel_column == 10'd0);
  assign frame_tick  = pix_zero & ~pix_zero_d;
  assign start_pulse = btn_start & ~start_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pix_zero_d <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      pix_zero_d <= pix_zero;
      start_d    <= btn_start;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Collision beats a coincident frame tick: the game ends without scoring it.
  always_comb begin
    state_next = state;
    score_next = score;
    case (state)
      IDLE: begin
        if (start_pulse && !collison_detect) begin
          state_next = PLAY;
          score_next = '0;
        end
      end
      PLAY: begin
        if (collison_detect) begin
          state_next = OVER;
        end else if (frame_tick && (score != SCORE_MAX)) begin
          score_next = score + SCORE_W'(1);
        end
      end
      OVER: begin
        if (start_pulse) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    dir = 2'b00;
    if (state == PLAY) begin
      case ({btn_left, btn_right})
        2'b10:   dir = 2'b10;
        2'b01:   dir = 2'b01;
        default: dir = 2'b00;
      endcase
    end
  end

  assign level          = (score >= LEVEL_THRESH);
  assign info_next      = {3'b000, level, state, dir};
  assign game_over_next = (state_next == OVER);

  // x^8+x^6+x^5+x^4+1; the all-zero lock-up state is escaped by reseeding.
  assign lfsr_fb   = randomized_value[7] ^ randomized_value[5]
                   ^ randomized_value[4] ^ randomized_value[3];
  assign lfsr_next = (randomized_value == 8'h00) ? LFSR_SEED
                                                 : {randomized_value[6:0], lfsr_fb};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      game_info_reg    <= 8'h00;
      randomized_value <= LFSR_SEED;
      score            <= '0;
      game_over        <= 1'b0;
    end else begin
      game_info_reg    <= info_next;
      randomized_value <= lfsr_next;
      score            <= score_next;
      game_over        <= game_over_next;
    end
  end

endmodule
`default_nettype wire
